rhs_axil_regfile: RTL

- AXI4-Lite slave register file for the RHS stimulation/recording controller.
- Responder to the processor-side AXI4-Lite master.
- Decodes the 0x00–0x20 register map (control, stim magnitude, packet length, ZCheck, stim channel, pulse width, intrapulse delay, pulse count, status).
- Drives configuration fields into the RHS sequencer and reports sequencer status back.

---
 rtl/rhs_axil_regfile.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/rhs_axil_regfile.sv
// AXI4-Lite register file for the RHS stimulation/recording controller.
// Holds sequencer configuration and reports sequencer status.
module rhs_axil_regfile #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              rhs_aclk,
  input  logic              rhs_aresetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [31:0]       ctrl,
  output logic              ctrl_wr,
  output logic [31:0]       stim_mag,
  output logic [7:0]        pkt_len,
  output logic [7:0]        zc_cycle,
  output logic [1:0]        zc_scale,
  output logic [4:0]        chan_pos,
  output logic [4:0]        chan_neg,
  output logic              chan_mono,
  output logic [15:0]       pulse_width,
  output logic [15:0]       ipulse_delay,
  output logic [7:0]        num_pulse,
  input  logic              stim_busy,
  input  logic              init_done,
  input  logic              mag_done
);

  logic        aw_full, w_full;
  logic [3:0]  widx;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        bvalid_q, ctrl_wr_q;
  logic [1:0]  bresp_q;
  logic        rvalid_q;
  logic [1:0]  rresp_q;
  logic [31:0] rdata_q;

  logic [31:0] ctrl_q, mag_q;
  logic [7:0]  pkt_q, np_q;
  logic [9:0]  zc_q;
  logic [10:0] chan_q;
  logic [15:0] pw_q, ipd_q;

  logic        wr_go, wr_err;
  logic [31:0] m;
  logic [3:0]  ridx;
  logic [31:0] rd_data;
  logic        unused;

  assign unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                    s_axi_awprot, s_axi_arprot};

  assign wr_go  = aw_full && w_full && !bvalid_q;
  assign wr_err = (widx >= 4'd8) || (widx != 4'd0 && stim_busy);
  assign m      = {{8{wstrb_q[3]}}, {8{wstrb_q[2]}},
                   {8{wstrb_q[1]}}, {8{wstrb_q[0]}}};

  always_ff @(posedge rhs_aclk or negedge rhs_aresetn) begin
    if (!rhs_aresetn) begin
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      widx      <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      ctrl_wr_q <= 1'b0;
      ctrl_q    <= '0;
      mag_q     <= '0;
      pkt_q     <= 8'd1;
      zc_q      <= '0;
      chan_q    <= '0;
      pw_q      <= 16'd1;
      ipd_q     <= '0;
      np_q      <= '0;
    end else begin
      ctrl_wr_q <= 1'b0;
      if (s_axi_awvalid && !aw_full) begin
        aw_full <= 1'b1;
        widx    <= s_axi_awaddr[5:2];
      end
      if (s_axi_wvalid && !w_full) begin
        w_full  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
      if (wr_go) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? 2'b10 : 2'b00;
        if (!wr_err) begin
          ctrl_wr_q <= (widx == 4'd0);
          case (widx)
            4'd0: ctrl_q <= (ctrl_q & ~m) | (wdata_q & m);
            4'd1: mag_q  <= (mag_q & ~m) | (wdata_q & m);
            4'd2: pkt_q  <= (pkt_q & ~m[7:0])
                            | (wdata_q[7:0] & m[7:0]);
            4'd3: zc_q   <= (zc_q & ~m[9:0])
                            | (wdata_q[9:0] & m[9:0]);
            4'd4: chan_q <= (chan_q & ~m[10:0])
                            | (wdata_q[10:0] & m[10:0]);
            4'd5: pw_q   <= (pw_q & ~m[15:0])
                            | (wdata_q[15:0] & m[15:0]);
            4'd6: ipd_q  <= (ipd_q & ~m[15:0])
                            | (wdata_q[15:0] & m[15:0]);
            4'd7: np_q   <= (np_q & ~m[7:0])
                            | (wdata_q[7:0] & m[7:0]);
            default: ;
          endcase
        end
      end
      if (bvalid_q && s_axi_bready) begin
        bvalid_q <= 1'b0;
        aw_full  <= 1'b0;
        w_full   <= 1'b0;
      end
    end
  end

  assign ridx = s_axi_araddr[5:2];

  always_comb begin
    rd_data = '0;
    case (ridx)
      4'd0: rd_data = ctrl_q;
      4'd1: rd_data = mag_q;
      4'd2: rd_data = {24'b0, pkt_q};
      4'd3: rd_data = {22'b0, zc_q};
      4'd4: rd_data = {21'b0, chan_q};
      4'd5: rd_data = {16'b0, pw_q};
      4'd6: rd_data = {16'b0, ipd_q};
      4'd7: rd_data = {24'b0, np_q};
      4'd8: rd_data = {29'b0, mag_done, init_done, stim_busy};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge rhs_aclk or negedge rhs_aresetn) begin
    if (!rhs_aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= 2'b00;
    end else if (s_axi_arvalid && !rvalid_q) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= (ridx > 4'd8) ? 2'b10 : 2'b00;
    end else if (rvalid_q && s_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axi_awready = !aw_full;
  assign s_axi_wready  = !w_full;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = !rvalid_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign ctrl         = ctrl_q;
  assign ctrl_wr      = ctrl_wr_q;
  assign stim_mag     = mag_q;
  assign pkt_len      = pkt_q;
  assign zc_cycle     = zc_q[7:0];
  assign zc_scale     = zc_q[9:8];
  assign chan_pos     = chan_q[4:0];
  assign chan_neg     = chan_q[9:5];
  assign chan_mono    = chan_q[10];
  assign pulse_width  = pw_q;
  assign ipulse_delay = ipd_q;
  assign num_pulse    = np_q;

endmodule
